peregrine_pif_initiator: RTL and testbench

- Inbound PIF master. Converts simple local read/write commands into PIF requests on the core's inbound PIF slave port (PIReq*), and collects the PIF responses (PORespValid and related).
- Used by DMA-style test agents and co-simulation drivers to load and inspect core-local IRAM/DRAM through the core.
- One transaction is outstanding at a time.

---
 rtl/peregrine_pif_initiator_if.sv | 35 +++
 rtl/peregrine_pif_initiator.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_peregrine_pif_initiator.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/peregrine_pif_initiator_if.sv
// peregrine_pif_initiator_if -- PIF request/response bundle between the
// initiator (master modport) and the core's inbound PIF slave port
// (slave modport). Signal names follow the core's PIF pin names.
`timescale 1ns/1ps

interface peregrine_pif_initiator_if;
    logic        PIReqValid;
    logic        POReqRdy;
    logic [7:0]  PIReqCntl;
    logic [31:0] PIReqAdrs;
    logic [31:0] PIReqData;
    logic [3:0]  PIReqDataBE;
    logic [5:0]  PIReqId;
    logic [1:0]  PIReqPriority;
    logic        PORespValid;
    logic        PIRespRdy;
    logic [7:0]  PORespCntl;
    logic [31:0] PORespData;
    logic [5:0]  PORespId;
    logic [1:0]  PORespPriority;

    modport master (
        output PIReqValid, PIReqCntl, PIReqAdrs, PIReqData, PIReqDataBE,
               PIReqId, PIReqPriority, PIRespRdy,
        input  POReqRdy, PORespValid, PORespCntl, PORespData, PORespId,
               PORespPriority
    );

    modport slave (
        input  PIReqValid, PIReqCntl, PIReqAdrs, PIReqData, PIReqDataBE,
               PIReqId, PIReqPriority, PIRespRdy,
        output POReqRdy, PORespValid, PORespCntl, PORespData, PORespId,
               PORespPriority
    );
endinterface

// File: rtl/peregrine_pif_initiator.sv
// peregrine_pif_initiator -- inbound PIF master. Turns local read/write
// commands into one outstanding PIF request at a time and hands the PIF
// response beats back on the rsp_* port with an error code.
// Optional feature: define PIF_INIT_TIMEOUT_EN to add a response watchdog
// that closes a stalled transaction with rsp_err=11 after TIMEOUT_CYCLES.
`timescale 1ns/1ps

module peregrine_pif_initiator #(
    parameter logic [5:0] ID_BASE        = 6'd0,
    parameter int         BLK_EN         = 1,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic        CLK,
    input  logic        BResetN,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_len,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_be,
    input  logic [1:0]  cmd_pri,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic [1:0]  rsp_err,
    peregrine_pif_initiator_if.master pif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    // Effective length: writes are always single, reserved code 3 is single,
    // and block reads collapse to single when block support is disabled.
    function automatic logic [1:0] eff_len(input logic wr, input logic [1:0] len);
        logic [1:0] res;
        if (wr || (BLK_EN == 0)) begin
            res = 2'd0;
        end else begin
            case (len)
                2'd1:    res = 2'd1;
                2'd2:    res = 2'd2;
                default: res = 2'd0;
            endcase
        end
        return res;
    endfunction

    // PIF control byte {opcode, blksz, 0, last} for a request.
    function automatic logic [7:0] req_cntl(input logic wr, input logic [1:0] len);
        logic [7:0] res;
        case (len)
            2'd1:    res = 8'h11;
            2'd2:    res = 8'h15;
            default: res = wr ? 8'h81 : 8'h01;
        endcase
        return res;
    endfunction

    // Request address aligned to the transfer size.
    function automatic logic [31:0] req_adrs(input logic [31:0] addr, input logic [1:0] len);
        logic [31:0] res;
        case (len)
            2'd1:    res = {addr[31:3], 3'b000};
            2'd2:    res = {addr[31:4], 4'b0000};
            default: res = {addr[31:2], 2'b00};
        endcase
        return res;
    endfunction

    // Number of response beats expected for a length code.
    function automatic logic [2:0] req_beats(input logic [1:0] len);
        logic [2:0] res;
        case (len)
            2'd1:    res = 3'd2;
            2'd2:    res = 3'd4;
            default: res = 3'd1;
        endcase
        return res;
    endfunction

    state_e      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        req_valid_q, req_valid_d;
    logic [7:0]  req_cntl_q, req_cntl_d;
    logic [31:0] req_adrs_q, req_adrs_d;
    logic [31:0] req_data_q, req_data_d;
    logic [3:0]  req_be_q, req_be_d;
    logic [5:0]  req_id_q, req_id_d;
    logic [1:0]  req_pri_q, req_pri_d;
    logic        write_q, write_d;
    logic [2:0]  beats_exp_q, beats_exp_d;
    logic [2:0]  beat_cnt_q, beat_cnt_d;

    logic [1:0]  len_s;
    logic        in_resp_s;
    logic        tmo_hit_s;
    logic        beat_fire_s;
    logic        txn_done_s;
    logic        rsp_valid_s;
    logic [31:0] rsp_data_s;
    logic        rsp_last_s;
    logic [1:0]  rsp_err_s;
    logic        resp_rdy_s;

    assign len_s     = eff_len(cmd_write, cmd_len);
    assign in_resp_s = (state_q == ST_RESP);

`ifdef PIF_INIT_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit_s = in_resp_s && (tmo_cnt_q >= TMO_LIMIT);

    // Watchdog: clear on RESP entry and on each beat, count RESP cycles, saturate at the limit.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if ((state_q == ST_REQ) && pif.POReqRdy) begin
            tmo_cnt_d = 16'd0;
        end else if (in_resp_s && beat_fire_s) begin
            tmo_cnt_d = 16'd0;
        end else if (in_resp_s && (tmo_cnt_q < TMO_LIMIT)) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge CLK or negedge BResetN) begin
        if (!BResetN) begin
            tmo_cnt_q <= 16'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_tmo_s;

    assign tmo_hit_s    = 1'b0;
    assign unused_tmo_s = ^TMO_LIMIT;
`endif

    // Response path: pass core beats through during RESP, or present the timeout beat.
    always_comb begin
        resp_rdy_s  = 1'b0;
        rsp_valid_s = 1'b0;
        rsp_data_s  = 32'd0;
        rsp_last_s  = 1'b0;
        rsp_err_s   = 2'b00;
        if (tmo_hit_s) begin
            rsp_valid_s = 1'b1;
            rsp_last_s  = 1'b1;
            rsp_err_s   = 2'b11;
        end else if (in_resp_s) begin
            resp_rdy_s  = rsp_ready;
            rsp_valid_s = pif.PORespValid;
            rsp_data_s  = write_q ? 32'd0 : pif.PORespData;
            rsp_last_s  = pif.PORespCntl[0] || ((beat_cnt_q + 3'd1) == beats_exp_q);
            if (pif.PORespCntl[2:1] != 2'b00) begin
                rsp_err_s = 2'b01;
            end else if (pif.PORespId != req_id_q) begin
                rsp_err_s = 2'b10;
            end else begin
                rsp_err_s = 2'b00;
            end
        end else begin
            resp_rdy_s = 1'b0;
        end
    end

    assign beat_fire_s = in_resp_s && !tmo_hit_s && pif.PORespValid && rsp_ready;
    assign txn_done_s  = (beat_fire_s && rsp_last_s) || (tmo_hit_s && rsp_ready);

    // Next-state and next-output computation for the IDLE/REQ/RESP sequencer.
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_cntl_d  = req_cntl_q;
        req_adrs_d  = req_adrs_q;
        req_data_d  = req_data_q;
        req_be_d    = req_be_q;
        req_id_d    = req_id_q;
        req_pri_d   = req_pri_q;
        write_d     = write_q;
        beats_exp_d = beats_exp_q;
        beat_cnt_d  = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = ST_REQ;
                    req_valid_d = 1'b1;
                    req_cntl_d  = req_cntl(cmd_write, len_s);
                    req_adrs_d  = req_adrs(cmd_addr, len_s);
                    req_data_d  = cmd_write ? cmd_wdata : 32'd0;
                    req_be_d    = cmd_write ? cmd_be : 4'hF;
                    req_pri_d   = cmd_pri;
                    write_d     = cmd_write;
                    beats_exp_d = req_beats(len_s);
                    beat_cnt_d  = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (pif.POReqRdy) begin
                    state_d     = ST_RESP;
                    req_valid_d = 1'b0;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RESP: begin
                if (txn_done_s) begin
                    state_d    = ST_IDLE;
                    req_id_d   = req_id_q + 6'd1;
                    beat_cnt_d = 3'd0;
                end else if (beat_fire_s) begin
                    beat_cnt_d = beat_cnt_q + 3'd1;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_valid_d = 1'b0;
            end
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // Sequencer state and registered request outputs.
    always_ff @(posedge CLK or negedge BResetN) begin
        if (!BResetN) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            req_valid_q <= 1'b0;
            req_cntl_q  <= 8'd0;
            req_adrs_q  <= 32'd0;
            req_data_q  <= 32'd0;
            req_be_q    <= 4'd0;
            req_id_q    <= ID_BASE;
            req_pri_q   <= 2'd0;
            write_q     <= 1'b0;
            beats_exp_q <= 3'd1;
            beat_cnt_q  <= 3'd0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            req_valid_q <= req_valid_d;
            req_cntl_q  <= req_cntl_d;
            req_adrs_q  <= req_adrs_d;
            req_data_q  <= req_data_d;
            req_be_q    <= req_be_d;
            req_id_q    <= req_id_d;
            req_pri_q   <= req_pri_d;
            write_q     <= write_d;
            beats_exp_q <= beats_exp_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign cmd_ready         = cmd_ready_q;
    assign pif.PIReqValid    = req_valid_q;
    assign pif.PIReqCntl     = req_cntl_q;
    assign pif.PIReqAdrs     = req_adrs_q;
    assign pif.PIReqData     = req_data_q;
    assign pif.PIReqDataBE   = req_be_q;
    assign pif.PIReqId       = req_id_q;
    assign pif.PIReqPriority = req_pri_q;
    assign pif.PIRespRdy     = resp_rdy_s;
    assign rsp_valid         = rsp_valid_s;
    assign rsp_data          = rsp_data_s;
    assign rsp_last          = rsp_last_s;
    assign rsp_err           = rsp_err_s;

    // Response type and priority carry nothing this initiator acts on.
    logic unused_s;
    assign unused_s = ^{pif.PORespPriority, pif.PORespCntl[7:3]};

endmodule

// File: tb/tb_peregrine_pif_initiator.sv
// tb_peregrine_pif_initiator -- randomized bench acting as command source,
// response sink and PIF slave, checked against a transaction-level model.
`timescale 1ns/1ps

module tb_peregrine_pif_initiator;
`ifdef PIF_INIT_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 1024;
`endif

    logic        CLK = 1'b0;
    logic        BResetN;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_len, cmd_pri;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_be;
    logic        rsp_valid, rsp_ready, rsp_last;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;

    peregrine_pif_initiator_if pif_bus ();

    peregrine_pif_initiator #(
        .ID_BASE(6'd0), .BLK_EN(1), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK(CLK), .BResetN(BResetN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_len(cmd_len), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_be(cmd_be), .cmd_pri(cmd_pri),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err),
        .pif(pif_bus)
    );

    always #5 CLK = ~CLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_id  = 0;
    logic [31:0] rd_data [4];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: beats per command.
    function automatic int model_beats(input logic wr, input logic [1:0] len);
        if (!wr && len == 2'd1) return 2;
        if (!wr && len == 2'd2) return 4;
        return 1;
    endfunction

    // Reference model: request control byte.
    function automatic logic [7:0] model_cntl(input logic wr, input int nb);
        if (wr) return 8'h81;
        if (nb == 2) return 8'h11;
        if (nb == 4) return 8'h15;
        return 8'h01;
    endfunction

    task automatic run_txn(input logic wr, input logic [1:0] len, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, input logic [1:0] pri,
                           input int rdy_dly, input int err_beat, input int early, input bit bad_id);
        int          nb, guard, beat, idle_cyc;
        bit          offered, done, e_last;
        logic [7:0]  e_cntl;
        logic [31:0] e_adrs;
        logic [1:0]  e_err;
        nb     = model_beats(wr, len);
        e_cntl = model_cntl(wr, nb);
        e_adrs = addr - (addr % 32'(nb * 4));
        guard  = 0;
        @(negedge CLK);
        while (!cmd_ready && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        check_val("cmd_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_len = len; cmd_addr = addr;
        cmd_wdata = wdata; cmd_be = be; cmd_pri = pri;
        @(negedge CLK);
        cmd_valid = 1'b0; cmd_addr = $urandom(); cmd_wdata = $urandom();
        cmd_be = 4'($urandom()); cmd_pri = 2'($urandom()); cmd_write = ~wr;
        for (int k = 0; k <= rdy_dly; k++) begin
            check_val("req_valid", {31'd0, pif_bus.PIReqValid}, 32'd1);
            check_val("req_cntl", {24'd0, pif_bus.PIReqCntl}, {24'd0, e_cntl});
            check_val("req_adrs", pif_bus.PIReqAdrs, e_adrs);
            check_val("req_be", {28'd0, pif_bus.PIReqDataBE}, wr ? {28'd0, be} : 32'hF);
            check_val("req_id", {26'd0, pif_bus.PIReqId}, 32'(exp_id));
            check_val("req_pri", {30'd0, pif_bus.PIReqPriority}, {30'd0, pri});
            if (wr) check_val("req_data", pif_bus.PIReqData, wdata);
            pif_bus.POReqRdy = (k == rdy_dly);
            @(negedge CLK);
        end
        pif_bus.POReqRdy = 1'b0;
        check_val("req_drop", {31'd0, pif_bus.PIReqValid}, 32'd0);
        beat = 0; offered = 0; idle_cyc = 0; done = 0; guard = 0;
        while (!done && guard < 200) begin
            guard++;
            if (!offered) pif_bus.PORespValid = 1'b0;
            if (!offered && ($urandom_range(3) != 0 || idle_cyc >= 3)) begin
                offered = 1;
                pif_bus.PORespValid = 1'b1;
                pif_bus.PORespData  = wr ? $urandom() : rd_data[beat];
                pif_bus.PORespId    = bad_id ? 6'(exp_id ^ 21) : 6'(exp_id);
                pif_bus.PORespPriority = 2'($urandom());
                pif_bus.PORespCntl  = {wr ? 4'h8 : 4'h0, 1'b0,
                                       (beat == err_beat) ? 2'b01 : 2'b00,
                                       (beat == nb - 1) || (beat == early)};
            end
            rsp_ready = (idle_cyc >= 3) ? 1'b1 : 1'($urandom_range(1));
            #1;
            check_val("rsp_valid", {31'd0, rsp_valid}, {31'd0, pif_bus.PORespValid});
            check_val("resp_rdy", {31'd0, pif_bus.PIRespRdy}, {31'd0, rsp_ready});
            if (offered && rsp_ready) begin
                e_last = (beat == nb - 1) || (beat == early);
                e_err  = (beat == err_beat) ? 2'b01 : (bad_id ? 2'b10 : 2'b00);
                check_val("rsp_data", rsp_data, wr ? 32'd0 : rd_data[beat]);
                check_val("rsp_last", {31'd0, rsp_last}, {31'd0, e_last});
                check_val("rsp_err", {30'd0, rsp_err}, {30'd0, e_err});
                beat++; offered = 0; idle_cyc = 0; done = e_last;
            end else begin
                idle_cyc++;
            end
            @(negedge CLK);
        end
        pif_bus.PORespValid = 1'b0;
        rsp_ready = 1'b0;
        if (!done) check_val("rsp_budget", 32'd0, 32'd1);
        exp_id = (exp_id + 1) % 64;
    endtask

    // PORespValid outside RESP must not reach the sink.
    task automatic stray_check();
        @(negedge CLK);
        pif_bus.PORespValid = 1'b1; pif_bus.PORespId = 6'(exp_id);
        pif_bus.PORespCntl = 8'h01; rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_val("stray_valid", {31'd0, rsp_valid}, 32'd0);
            check_val("stray_rdy", {31'd0, pif_bus.PIRespRdy}, 32'd0);
            @(negedge CLK);
        end
        pif_bus.PORespValid = 1'b0; rsp_ready = 1'b0;
    endtask

`ifdef PIF_INIT_TIMEOUT_EN
    task automatic run_timeout();
        int cyc;
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_len = 2'd0; cmd_addr = 32'h100;
        @(negedge CLK);
        cmd_valid = 1'b0; pif_bus.POReqRdy = 1'b1;
        @(negedge CLK);
        pif_bus.POReqRdy = 1'b0; rsp_ready = 1'b0; cyc = 0;
        while (!rsp_valid && cyc < 50) begin
            @(negedge CLK);
            cyc++;
        end
        check_val("tmo_cycles", 32'(cyc), 32'(TMO));
        check_val("tmo_err", {30'd0, rsp_err}, 32'd3);
        check_val("tmo_last", {31'd0, rsp_last}, 32'd1);
        check_val("tmo_data", rsp_data, 32'd0);
        @(negedge CLK);
        check_val("tmo_hold", {31'd0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b1;
        pif_bus.PORespValid = 1'b1; pif_bus.PORespId = 6'(exp_id); pif_bus.PORespCntl = 8'h01;
        exp_id = (exp_id + 1) % 64;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_val("late_ignored", {31'd0, rsp_valid}, 32'd0);
            @(negedge CLK);
        end
        pif_bus.PORespValid = 1'b0; rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        int          nb, eb, el;
        logic        wr;
        logic [1:0]  len;
        BResetN = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_len = 2'd0;
        cmd_addr = 32'd0; cmd_wdata = 32'd0; cmd_be = 4'd0; cmd_pri = 2'd0;
        rsp_ready = 1'b0;
        pif_bus.POReqRdy = 1'b0; pif_bus.PORespValid = 1'b0; pif_bus.PORespCntl = 8'd0;
        pif_bus.PORespData = 32'd0; pif_bus.PORespId = 6'd0; pif_bus.PORespPriority = 2'd0;
        #12;
        check_val("rst_req_valid", {31'd0, pif_bus.PIReqValid}, 32'd0);
        check_val("rst_req_id", {26'd0, pif_bus.PIReqId}, 32'd0);
        check_val("rst_req_adrs", pif_bus.PIReqAdrs, 32'd0);
        check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("rst_resp_rdy", {31'd0, pif_bus.PIRespRdy}, 32'd0);
        @(negedge CLK); BResetN = 1'b1;
        repeat (2) @(negedge CLK);
        check_val("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Directed single write with 3 cycles of request backpressure.
        run_txn(1'b1, 2'd0, 32'h4000_0006, 32'hDEAD_BEEF, 4'hC, 2'd1, 3, -1, -1, 1'b0);
        // Directed 4-beat block read.
        rd_data[0] = 32'h11; rd_data[1] = 32'h22; rd_data[2] = 32'h33; rd_data[3] = 32'h44;
        run_txn(1'b0, 2'd2, 32'h4000_001C, 32'd0, 4'h0, 2'd2, 1, -1, -1, 1'b0);
        // Bus error on a single read, then a command must still be accepted.
        rd_data[0] = 32'hCAFE_0001;
        run_txn(1'b0, 2'd0, 32'h0000_0040, 32'd0, 4'h0, 2'd0, 0, 0, -1, 1'b0);
        // Wrong response ID.
        run_txn(1'b0, 2'd0, 32'h0000_0044, 32'd0, 4'h0, 2'd3, 0, -1, -1, 1'b1);
        // Early last on a 4-beat read.
        rd_data[0] = 32'hA; rd_data[1] = 32'hB;
        run_txn(1'b0, 2'd2, 32'h0000_0080, 32'd0, 4'h0, 2'd0, 0, -1, 1, 1'b0);
        stray_check();

        // Reset in the middle of a request.
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_len = 2'd1; cmd_addr = 32'h1234;
        @(negedge CLK);
        cmd_valid = 1'b0;
        check_val("mid_req_valid", {31'd0, pif_bus.PIReqValid}, 32'd1);
        #2 BResetN = 1'b0;
        #1;
        check_val("mid_rst_valid", {31'd0, pif_bus.PIReqValid}, 32'd0);
        check_val("mid_rst_id", {26'd0, pif_bus.PIReqId}, 32'd0);
        @(negedge CLK); BResetN = 1'b1; exp_id = 0;
        repeat (2) @(negedge CLK);
        check_val("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        // 65 single reads: IDs run 0..63 and wrap back to 0.
        for (int i = 0; i < 65; i++) begin
            rd_data[0] = $urandom();
            run_txn(1'b0, 2'd0, $urandom(), 32'd0, 4'h0, 2'($urandom()),
                    $urandom_range(1), -1, -1, 1'b0);
        end

        // Randomized mix.
        for (int i = 0; i < 40; i++) begin
            wr  = 1'($urandom_range(1));
            len = 2'($urandom_range(3));
            nb  = model_beats(wr, len);
            for (int j = 0; j < 4; j++) rd_data[j] = $urandom();
            eb = ($urandom_range(5) == 0) ? int'($urandom_range(nb - 1)) : -1;
            el = (nb > 1 && $urandom_range(5) == 0) ? int'($urandom_range(nb - 2)) : -1;
            run_txn(wr, len, $urandom(), $urandom(), 4'($urandom()), 2'($urandom()),
                    $urandom_range(3), eb, el, ($urandom_range(7) == 0));
        end

`ifdef PIF_INIT_TIMEOUT_EN
        run_timeout();
        rd_data[0] = 32'h5555_AAAA;
        run_txn(1'b0, 2'd0, 32'h200, 32'd0, 4'h0, 2'd0, 0, -1, -1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
